// File: rtl/telemetry_rx.sv
// rtl/telemetry_rx.sv - 8N1 UART receiver and telemetry frame parser for the eBike TX stream
module telemetry_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        err
);

    localparam logic [11:0] FULL_M1 = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_M1 = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {P_HUNT, P_SYNC, P_PAYLOAD} p_state_e;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [11:0] baud_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;

    logic rx_fall, half_hit, full_hit;
    logic cnt_clr, tick, shift_en, byte_rdy, frame_err;

    p_state_e    p_state_q, p_state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] batt_sh_q, curr_sh_q;
    logic [3:0]  torque_hi_q;
    logic [11:0] batt_q, curr_q, torque_q;
    logic        vld_q, err_q;
    logic        nib_bad, hi_bad, frame_done, shadow_we;

    // Third flop only remembers the previous synchronized level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall  = rx_prev_q & ~rx_sync_q;
    assign half_hit = (baud_cnt_q == HALF_M1);
    assign full_hit = (baud_cnt_q == FULL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
        end else begin
            rx_state_q <= rx_state_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
            RX_START: if (half_hit) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_cnt_q == 4'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (full_hit) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr   = 1'b0;
        tick      = 1'b0;
        shift_en  = 1'b0;
        byte_rdy  = 1'b0;
        frame_err = 1'b0;
        case (rx_state_q)
            RX_IDLE:  cnt_clr = 1'b1;
            RX_START: tick = half_hit;
            RX_DATA: begin
                tick     = full_hit;
                shift_en = full_hit;
            end
            RX_STOP: begin
                tick      = full_hit;
                byte_rdy  = full_hit & rx_sync_q;
                frame_err = full_hit & ~rx_sync_q;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            baud_cnt_q <= (cnt_clr || tick) ? 12'd0 : baud_cnt_q + 12'd1;
            if (cnt_clr) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (shift_en) begin
                shift_q <= {rx_sync_q, shift_q[7:1]};
            end
        end
    end

    // Even payload indices carry a high nibble; their upper four bits must be clear.
    assign nib_bad = ~idx_q[0] & (|shift_q[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q <= P_HUNT;
            idx_q     <= '0;
        end else begin
            p_state_q <= p_state_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        idx_d     = idx_q;
        if (frame_err) begin
            p_state_d = P_HUNT;
        end else if (byte_rdy) begin
            case (p_state_q)
                P_HUNT: if (shift_q == 8'hAA) p_state_d = P_SYNC;
                P_SYNC: begin
                    if (shift_q == 8'h55) begin
                        p_state_d = P_PAYLOAD;
                        idx_d     = 3'd0;
                    end else if (shift_q != 8'hAA) begin
                        p_state_d = P_HUNT;
                    end
                end
                P_PAYLOAD: begin
                    if (nib_bad || idx_q == 3'd5) begin
                        p_state_d = P_HUNT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: p_state_d = P_HUNT;
            endcase
        end
    end

    always_comb begin
        hi_bad     = 1'b0;
        frame_done = 1'b0;
        shadow_we  = 1'b0;
        if (byte_rdy && p_state_q == P_PAYLOAD) begin
            hi_bad     = nib_bad;
            shadow_we  = ~nib_bad;
            frame_done = ~nib_bad & (idx_q == 3'd5);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batt_sh_q   <= '0;
            curr_sh_q   <= '0;
            torque_hi_q <= '0;
            batt_q      <= '0;
            curr_q      <= '0;
            torque_q    <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            vld_q <= frame_done;
            err_q <= frame_err | hi_bad;
            if (shadow_we) begin
                case (idx_q)
                    3'd0: batt_sh_q[11:8] <= shift_q[3:0];
                    3'd1: batt_sh_q[7:0]  <= shift_q;
                    3'd2: curr_sh_q[11:8] <= shift_q[3:0];
                    3'd3: curr_sh_q[7:0]  <= shift_q;
                    3'd4: torque_hi_q     <= shift_q[3:0];
                    default: ;
                endcase
            end
            // All three readings commit together on the torque_lo byte.
            if (frame_done) begin
                batt_q   <= batt_sh_q;
                curr_q   <= curr_sh_q;
                torque_q <= {torque_hi_q, shift_q};
            end
        end
    end

    assign batt   = batt_q;
    assign curr   = curr_q;
    assign torque = torque_q;
    assign vld    = vld_q;
    assign err    = err_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// tb/tb_telemetry_rx.sv - randomized bench for telemetry_rx against a byte-stream frame model
module tb_telemetry_rx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic [11:0] batt, curr, torque;
    logic        vld, err;

    always #5 clk = ~clk;

    telemetry_rx #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX),
        .batt(batt), .curr(curr), .torque(torque),
        .vld(vld), .err(err)
    );

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int n_vld = 0, n_err = 0;
    int excl_bad = 0, width_bad = 0, atom_bad = 0;
    int vld_t[$];
    logic pv = 1'b0, pe = 1'b0;
    logic [11:0] pb = '0, pc = '0, pt = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (vld) begin
                n_vld++;
                vld_t.push_back(cyc);
            end
            if (err) n_err++;
            if (vld && err) excl_bad++;
            if ((vld && pv) || (err && pe)) width_bad++;
            if (!vld && (batt != pb || curr != pc || torque != pt)) atom_bad++;
        end
        pv = vld;
        pe = err;
        pb = batt;
        pc = curr;
        pt = torque;
    end

    logic [7:0]  q_m[$];
    int          m_vld = 0, m_err = 0;
    logic [11:0] e_b = '0, e_c = '0, e_t = '0;

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            m_err++;
            q_m.delete();
        end else if (q_m.size() == 0) begin
            if (b == 8'hAA) q_m.push_back(b);
        end else if (q_m.size() == 1) begin
            if (b == 8'h55) q_m.push_back(b);
            else if (b != 8'hAA) q_m.delete();
        end else begin
            q_m.push_back(b);
            if ((q_m.size() == 3 || q_m.size() == 5 || q_m.size() == 7) && b > 8'h0F) begin
                m_err++;
                q_m.delete();
            end else if (q_m.size() == 8) begin
                e_b = 12'(int'(q_m[2]) * 256 + int'(q_m[3]));
                e_c = 12'(int'(q_m[4]) * 256 + int'(q_m[5]));
                e_t = 12'(int'(q_m[6]) * 256 + int'(q_m[7]));
                m_vld++;
                q_m.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_nvld"}, n_vld, m_vld);
        chk({tag, "_nerr"}, n_err, m_err);
        chk({tag, "_batt"}, int'(batt), int'(e_b));
        chk({tag, "_curr"}, int'(curr), int'(e_c));
        chk({tag, "_torque"}, int'(torque), int'(e_t));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
        RX = 1'b0;
        wait_clk(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_clk(BD);
        end
        RX = stop_ok;
        wait_clk(BD);
        RX = 1'b1;
        model_byte(b, stop_ok);
        if (!stop_ok) wait_clk(BD);
        wait_clk(gap);
    endtask

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                              input int gap, input int bad_nib, input int bad_stop);
        logic [7:0] fr [8];
        fr[0] = 8'hAA;
        fr[1] = 8'h55;
        fr[2] = {4'h0, b[11:8]};
        fr[3] = b[7:0];
        fr[4] = {4'h0, c[11:8]};
        fr[5] = c[7:0];
        fr[6] = {4'h0, t[11:8]};
        fr[7] = t[7:0];
        if (bad_nib >= 0) fr[bad_nib] = fr[bad_nib] | 8'h10;
        for (int i = 0; i < 8; i++) begin
            send_byte(fr[i], i != bad_stop, gap);
        end
    endtask

    initial begin
        int sz;
        rst_n = 1'b0;
        wait_clk(3);
        chk("rst_batt", int'(batt), 0);
        chk("rst_curr", int'(curr), 0);
        chk("rst_torque", int'(torque), 0);
        chk("rst_vld", int'(vld), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_clk(2 * BD);

        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h0A, 1'b1, 0);
        send_byte(8'hBC, 1'b1, 0);
        send_byte(8'h04, 1'b1, 0);
        send_byte(8'h56, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        chk("pre_batt", int'(batt), 0);
        chk("pre_nvld", n_vld, 0);
        send_byte(8'h7F, 1'b1, 0);
        wait_clk(4);
        check_state("nominal");
        chk("nominal_batt_abs", int'(batt), 'hABC);
        chk("nominal_torque_abs", int'(torque), 'h07F);

        send_frame(12'h123, 12'h456, 12'h789, 0, -1, -1);
        send_frame(12'hFFF, 12'h000, 12'h800, 0, -1, -1);
        wait_clk(4);
        check_state("b2b");
        sz = vld_t.size();
        if (sz < 2) chk("b2b_count", sz, 2);
        else chk("b2b_spacing", vld_t[sz-1] - vld_t[sz-2], 80 * BD);

        send_byte(8'h13, 1'b1, 3);
        send_byte(8'hAA, 1'b1, 0);
        send_frame(12'h321, 12'h654, 12'h0E7, 0, -1, -1);
        wait_clk(4);
        check_state("resync");

        send_frame(12'h111, 12'h222, 12'h333, 0, -1, 5);
        wait_clk(4);
        check_state("badstop");
        chk("badstop_hold", int'(curr), 'h654);
        send_frame(12'h444, 12'h555, 12'h666, 2, -1, -1);
        wait_clk(4);
        check_state("after_badstop");

        send_frame(12'hA12, 12'h034, 12'h056, 0, 2, -1);
        wait_clk(4);
        check_state("badnib");
        chk("badnib_hold", int'(batt), 'h444);
        send_frame(12'h9AB, 12'h0CD, 12'h0EF, 0, -1, -1);
        wait_clk(4);
        check_state("after_badnib");

        RX = 1'b0;
        wait_clk(3);
        RX = 1'b1;
        wait_clk(3 * BD);
        check_state("glitch");

        send_byte(8'hAA, 1'b1, 0);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h0A, 1'b1, 0);
        RX = 1'b0;
        wait_clk(40);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_batt", int'(batt), 0);
        chk("mid_rst_curr", int'(curr), 0);
        chk("mid_rst_torque", int'(torque), 0);
        q_m.delete();
        e_b = '0;
        e_c = '0;
        e_t = '0;
        RX = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(BD);
        send_frame(12'h5A5, 12'h0F0, 12'hC3C, 0, -1, -1);
        wait_clk(4);
        check_state("after_rst");

        for (int it = 0; it < 25; it++) begin
            int kind, nj, idx;
            kind = int'($urandom_range(0, 9));
            nj = int'($urandom_range(0, 2));
            for (int j = 0; j < nj; j++) begin
                send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 20)));
            end
            idx = -1;
            if (kind == 0) idx = 2 * int'($urandom_range(1, 3));
            send_frame(12'($urandom), 12'($urandom), 12'($urandom),
                       int'($urandom_range(0, 20)), idx,
                       (kind == 1) ? int'($urandom_range(0, 7)) : -1);
            wait_clk(4);
            check_state("rand");
        end

        chk("excl_vld_err", excl_bad, 0);
        chk("pulse_width", width_bad, 0);
        chk("atomic_outputs", atom_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/telemetry_rx.md
# telemetry_rx

Receive-side decoder for the eBike serial telemetry stream. It deserializes the 8N1 UART line driven by the controller's `TX` output and parses the 8-byte telemetry frame. It recovers the 12-bit battery, current and torque readings and presents them as a registered, atomically updated set with a one-cycle valid strobe. It sits on the display/logging side of the link, or in the bench as the checker for the controller's `TX` pin.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clocks per bit, which is 19200 baud at 50 MHz. Legal range is 8 to 4095.

Ports:
- `clk`: input, 1 bit, 50 MHz system clock.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `RX`: input, 1 bit. Serial line, idles high, asynchronous to `clk`.
- `batt`: output, 12 bits. Last valid battery reading.
- `curr`: output, 12 bits. Last valid current reading.
- `torque`: output, 12 bits. Last valid torque reading.
- `vld`: output, 1 bit. One-cycle pulse when a complete, error-free frame has updated `batt`, `curr` and `torque`.
- `err`: output, 1 bit. One-cycle pulse on a framing error (bad stop bit) or a malformed payload byte.

## Operation
- **Input synchronizer:** `RX` passes through a 2-flop synchronizer. Both flops reset to 1.
- **Byte receiver states:** IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - START waits `BAUD_DIV/2` clocks (integer division), then re-samples the line. If the line is low, go to DATA. If it is high, treat it as a glitch and return to IDLE with no error.
  - DATA samples every `BAUD_DIV` clocks, LSB first, 8 bits.
  - STOP samples once after `BAUD_DIV` clocks. A value of 1 produces a byte-ready strobe. A value of 0 produces an `err` pulse, no byte, and forces the parser to HUNT.
  - After the stop-bit sample the receiver returns to IDLE immediately, so the next start edge is accepted from that point on.
- **Frame format:** 0xAA, 0x55, batt_hi, batt_lo, curr_hi, curr_lo, torque_hi, torque_lo.
  - `*_hi` carries value[11:8] in bits [3:0]. Bits [7:4] must be 0.
  - `*_lo` carries value[7:0].
- **Parser states:** HUNT, SYNC, PAYLOAD (byte index 0..5).
  - HUNT: a 0xAA byte moves to SYNC. Any other byte stays in HUNT with no error.
  - SYNC: 0x55 moves to PAYLOAD with index 0. 0xAA stays in SYNC. Any other byte returns to HUNT with no error.
  - PAYLOAD: bytes are captured into shadow registers.
    - A hi byte with a nonzero upper nibble produces an `err` pulse, discards the frame and returns to HUNT.
    - When index 5 is accepted, `batt`, `curr` and `torque` load from the shadow registers in the same clock, `vld` pulses and the parser returns to HUNT.
- **Atomicity:** outputs change only on `vld`. A partial or errored frame never alters them. Shadow registers are not visible.
- **Timeouts:** there is no inter-byte timeout. Arbitrary idle gaps between bytes of a frame are legal.

## Timing
- **Reset values:** `batt`, `curr` and `torque` are 0; `vld` and `err` are 0. Receiver is in IDLE, parser in HUNT, sync flops are 1.
- **Reset mid-operation:** asserting `rst_n` mid-byte or mid-frame returns everything to the reset state immediately and asynchronously. The partial frame is lost.
- **Sample points:** the start bit is sampled `BAUD_DIV/2` clocks after the synchronized falling edge. Data bit n is sampled `BAUD_DIV/2 + (n+1)·BAUD_DIV` clocks after that edge, and the stop bit at `BAUD_DIV/2 + 9·BAUD_DIV`. These figures are measured at the synchronizer output; add 2 clocks relative to raw `RX`.
- **Byte latency:** the byte-ready strobe asserts the cycle after the stop-bit sample. The parser consumes the byte in that same cycle.
- **Frame latency:** `vld` and the new output values appear together, 1 clock after the stop-bit sample of torque_lo. They are registered, not combinational.
- **Pulse width:** `vld` and `err` are exactly 1 clock. They are never asserted together.
- **Back-to-back traffic:** full-rate frames with zero idle between the stop bit and the next start bit must decode without loss. The worst-case stop-to-start spacing is half a bit.
- **Width rules:** bit counter is 4 bits. Baud counter is 12 bits, wraps to 0 on each sample and is cleared on IDLE -> START.

## Test plan
- **Nominal frame:** reset, then send AA 55 0A BC 04 56 00 7F at `BAUD_DIV`=16 -> single `vld` pulse; `batt`=0xABC, `curr`=0x456, `torque`=0x07F. Before the pulse the outputs read 0.
- **Back-to-back frames:** send two frames with no idle gap, the second carrying batt=0xFFF, curr=0x000, torque=0x800 -> two `vld` pulses spaced 80 bit-times apart; final outputs 0xFFF/0x000/0x800.
- **Resync:** send 13 AA AA 55 followed by a valid payload -> `vld` asserts with the correct values and `err` never asserts.
- **Bad stop bit:** drive a bad stop bit on curr_lo, then send a full valid frame -> one `err` pulse and the outputs hold their previous values. The next full frame then produces `vld`.
- **Bad high nibble:** send batt_hi=0x1A -> `err` pulse and no `vld`. A subsequent frame decodes correctly.
- **Glitch and reset:** a 3-clock low glitch on `RX` -> no byte and no `err`. Asserting `rst_n` low mid-payload of a frame -> all outputs read 0 immediately. The next complete frame decodes normally.
